ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) to keyboard.
- Sits beside the PS/2 receiver on the same open-drain ps2Clk/ps2Data pair, driven through top-level tri-states.
- Performs the inhibit / request-to-send sequence, shifts out data + odd parity + stop on device-generated clocks, then checks the device line-ACK.
- Receiver must ignore the bus while busy=1 (top-level gating).

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_sync_edge.sv | 41 ++++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and receiver.
package ps2_pkg;

  // Host transmitter sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RELEASE   = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Host-to-device command bytes.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // Device response bytes.
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  // Frame layout after the start bit: 8 data bits, parity at 8, stop at 9.
  localparam int unsigned BIT_IDX_W  = 4;
  localparam int unsigned PARITY_IDX = 8;
  localparam int unsigned STOP_IDX   = 9;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchroniser for the raw PS/2 clock/data lines plus a falling-edge strobe on clock.
module ps2_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic fall_c
);

  logic [STAGES-1:0] clk_sr;
  logic [STAGES-1:0] data_sr;
  logic              prev_clk;

  // Shift chains reset to the idle (released, high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_sr[0]  <= clk_in;
      data_sr[0] <= data_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        clk_sr[i]  <= clk_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
      prev_clk <= clk_sr[STAGES-1];
    end
  end

  assign sync_clk  = clk_sr[STAGES-1];
  assign sync_data = data_sr[STAGES-1];

  // One-cycle strobe when the synchronised clock goes high to low.
  assign fall_c = prev_clk & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift frame, check line ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDrive,
  output logic       ps2DataDrive,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       done,
  output logic       ackOk,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     INH_START = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0]     TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_PAR   = BIT_IDX_W'(PARITY_IDX);
  localparam logic [BIT_IDX_W-1:0] IDX_STOP  = BIT_IDX_W'(STOP_IDX);

  ps2_tx_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           sh_reg_q, sh_reg_d;
  logic                 parity_q, parity_d;
  logic                 clk_drv_q, clk_drv_d;
  logic                 data_drv_q, data_drv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ack_ok_q, ack_ok_d;
  logic                 error_q, error_d;

  logic sync_clk;
  logic sync_data;
  logic fall_c;
  logic accept_c;
  logic tmo_hit_c;
  logic tmo_state_c;

  ps2_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2ClkIn),
    .data_in   (ps2DataIn),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .fall_c    (fall_c)
  );

  assign accept_c    = txStart & ~busy_q;
  assign tmo_state_c = (state_q == RELEASE) || (state_q == SEND) ||
                       (state_q == ACK)     || (state_q == WAIT_IDLE);
  assign tmo_hit_c   = tmo_state_c && (cnt_q == TMO_LAST);

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      sh_reg_q   <= '0;
      parity_q   <= 1'b0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      sh_reg_q   <= sh_reg_d;
      parity_q   <= parity_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      error_q    <= error_d;
    end
  end

  // Next-state selection; timeout outranks any coincident strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept_c) state_d = INHIBIT;
      INHIBIT:   if (cnt_q == INH_START) state_d = RELEASE;
      RELEASE:   state_d = tmo_hit_c ? IDLE : SEND;
      SEND: begin
        if (tmo_hit_c)                        state_d = IDLE;
        else if (fall_c && bit_idx_q == IDX_STOP) state_d = ACK;
      end
      ACK: begin
        if (tmo_hit_c)   state_d = IDLE;
        else if (fall_c) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (tmo_hit_c)                   state_d = IDLE;
        else if (sync_clk && sync_data)  state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    sh_reg_d   = sh_reg_q;
    parity_d   = parity_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    busy_d     = busy_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          sh_reg_d   = txData;
          parity_d   = odd_parity(txData);
          busy_d     = 1'b1;
          clk_drv_d  = 1'b1;
          data_drv_d = 1'b0;
          cnt_d      = '0;
          ack_ok_d   = 1'b0;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Last inhibit cycle: assert the start bit while the clock is still held.
        if (cnt_q == INH_LAST) data_drv_d = 1'b1;
        if (cnt_q == INH_START) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b1;
          cnt_d      = '0;
          bit_idx_d  = '0;
        end
      end
      RELEASE, SEND, ACK, WAIT_IDLE: begin
        if (tmo_hit_c) begin
          error_d    = 1'b1;
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == SEND && fall_c) begin
            // Drive is active-low: pulling the line means sending a 0.
            if (bit_idx_q < IDX_PAR)       data_drv_d = ~sh_reg_q[bit_idx_q[2:0]];
            else if (bit_idx_q == IDX_PAR) data_drv_d = ~parity_q;
            else                           data_drv_d = 1'b0;
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
          if (state_q == ACK && fall_c) ack_ok_d = ~sync_data;
          if (state_q == WAIT_IDLE && sync_clk && sync_data) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign ps2ClkDrive  = clk_drv_q;
  assign ps2DataDrive = data_drv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ackOk        = ack_ok_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2ClkDrive, ps2DataDrive, busy, done, ackOk, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int error_cnt = 0;
  logic exp_q[$];

  // Open-drain wired-AND of host and device pull-downs.
  assign clk_line  = ~(ps2ClkDrive | dev_clk_low);
  assign data_line = ~(ps2DataDrive | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2ClkIn     (clk_line),
    .ps2DataIn    (data_line),
    .ps2ClkDrive  (ps2ClkDrive),
    .ps2DataDrive (ps2DataDrive),
    .txData       (tx_data),
    .txStart      (tx_start),
    .busy         (busy),
    .done         (done),
    .ackOk        (ackOk),
    .error        (error)
  );

  // Pulse counters used to prove exactly-once / never behaviour.
  always @(posedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (error) error_cnt <= error_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ACK, 1: no ACK, 2: device silent, 3: reset after 4 bits, 4: ACK + txStart while busy
  task automatic xfer(input logic [7:0] b, input int mode);
    int n_inh, n_lo, t, d0, e0;
    logic [9:0] rx;
    logic prev_b, exp_bit;
    d0 = done_cnt;
    e0 = error_cnt;
    rx = '0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);

    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    check("busy_after_accept", busy, 1);

    n_inh = 0;
    while (ps2ClkDrive && !ps2DataDrive && n_inh < INH + 100) begin
      if (mode == 4 && n_inh == 10) begin tx_data = 8'h55; tx_start = 1'b1; end
      else tx_start = 1'b0;
      n_inh++;
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("inhibit_cycles", n_inh, INH);
    n_lo = 0;
    while (ps2ClkDrive && n_lo < 100) begin n_lo++; @(negedge clk); end
    check("start_bit_clock_low_cycles", n_lo, 1);
    check("start_bit_line", data_line, 0);

    if (mode == 2) begin
      t = 0;
      while (!error && t < TMO + 100) begin @(negedge clk); t++; end
      check("timeout_latency", t, TMO);
      check("timeout_clk_drive", ps2ClkDrive, 0);
      check("timeout_data_drive", ps2DataDrive, 0);
      check("timeout_busy", busy, 0);
      @(negedge clk);
      check("error_one_cycle", error, 0);
      repeat (20) @(negedge clk);
      check("timeout_no_done", done_cnt, d0);
      check("timeout_one_error", error_cnt, e0 + 1);
      exp_q.delete();
      return;
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      rx[k] = data_line;
      if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
      else begin
        exp_bit = exp_q.pop_front();
        check($sformatf("line_bit%0d", k), rx[k], exp_bit);
      end
      if (mode == 3 && k == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clk_drive", ps2ClkDrive, 0);
        check("rst_data_drive", ps2DataDrive, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        repeat (HALF * 4) @(negedge clk);
        check("rst_no_done", done_cnt, d0);
        check("rst_no_error", error_cnt, e0);
        exp_q.delete();
        return;
      end
      repeat (HALF) @(negedge clk);
    end
    check("device_parity_odd", ^rx[8:0], 1);
    check("scoreboard_empty", exp_q.size(), 0);

    if (mode != 1) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;

    t = 0;
    prev_b = busy;
    while (!done && t < 300) begin prev_b = busy; @(negedge clk); t++; end
    check("done_seen", done, 1);
    check("ack_ok", ackOk, (mode != 1) ? 1 : 0);
    check("busy_before_done", prev_b, 1);
    check("busy_at_done", busy, 0);
    check("error_at_done", error, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (30) @(negedge clk);
    check("idle_clk_drive", ps2ClkDrive, 0);
    check("idle_busy", busy, 0);
    check("one_done_pulse", done_cnt, d0 + 1);
    check("no_error_pulse", error_cnt, e0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_clk_drive", ps2ClkDrive, 0);
    check("reset_data_drive", ps2DataDrive, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ack_ok", ackOk, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    xfer(CMD_SET_LED, 0);
    xfer(8'h01, 0);
    xfer(8'h00, 0);
    xfer(CMD_ECHO, 1);
    xfer(8'hA5, 2);
    xfer(8'h3C, 3);
    xfer(CMD_ENABLE, 0);
    xfer(CMD_RESET, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
